// File: rtl/branch_predictor_btb_pkg.sv
// Shared pipeline-wide constants for the branch predictor: default width,
// PC alignment and direction-counter encodings.
package branch_predictor_btb_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int PC_ALIGN     = 2;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr2_e;

   // Weak states for an arbitrary width: MSB clear/others set, or MSB set/others clear.
   function automatic int unsigned ctr_weak_not_taken(input int unsigned width);
      if (width == 2) return 32'(CTR_WNT);
      return (32'd1 << (width - 1)) - 32'd1;
   endfunction

   function automatic int unsigned ctr_weak_taken(input int unsigned width);
      if (width == 2) return 32'(CTR_WT);
      return 32'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup and execute resolve signals between the pipeline and the BTB.
interface branch_predictor_btb_if #(
   parameter int XLEN = 32
);
   logic            f_lookup_valid;
   logic [XLEN-1:0] f_pc;
   logic            f_predict_taken;
   logic [XLEN-1:0] f_predict_target;

   logic            x_update_valid;
   logic [XLEN-1:0] x_pc;
   logic            x_is_jump;
   logic            x_taken;
   logic [XLEN-1:0] x_target;
   logic            x_pred_taken;
   logic [XLEN-1:0] x_pred_target;
   logic            x_mispredict;

   modport master (
      output f_lookup_valid, f_pc,
      input  f_predict_taken, f_predict_target,
      output x_update_valid, x_pc, x_is_jump, x_taken, x_target,
      output x_pred_taken, x_pred_target,
      input  x_mispredict
   );

   modport slave (
      input  f_lookup_valid, f_pc,
      output f_predict_taken, f_predict_target,
      input  x_update_valid, x_pc, x_is_jump, x_taken, x_target,
      input  x_pred_taken, x_pred_target,
      output x_mispredict
   );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with load and set-to-max; used for the
// per-entry direction counters and the statistics counters.
module sat_counter #(
   parameter int               WIDTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             set_max,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value
);
   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   logic [WIDTH-1:0] value_reg;
   logic [WIDTH-1:0] value_next;

   always_comb begin
      value_next = value_reg;
      if (load) begin
         value_next = load_value;
      end else if (set_max) begin
         value_next = MAX_VAL;
      end else if (inc && !dec) begin
         if (value_reg != MAX_VAL) value_next = value_reg + WIDTH'(1);
      end else if (dec && !inc) begin
         if (value_reg != '0) value_next = value_reg - WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) value_reg <= RST_VAL;
      else       value_reg <= value_next;
   end

   assign value = value_reg;
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, combinational lookup, mispredict detection and saturating stats.
module branch_predictor_btb
   import branch_predictor_btb_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int ENTRIES    = 16,
   parameter int CTR_BITS   = 2,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   branch_predictor_btb_if.slave bus,
   output logic [STAT_WIDTH-1:0] stat_hits,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);
   localparam int IDX_BITS = $clog2(ENTRIES);
   localparam int TAG_BITS = XLEN - IDX_BITS - PC_ALIGN;

   localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(ctr_weak_taken(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;

   // Tag and target need no reset: valid_reg gates every use of them.
   logic [TAG_BITS-1:0]                tag_mem    [ENTRIES];
   logic [XLEN-1:0]                    target_mem [ENTRIES];
   logic [ENTRIES-1:0]                 valid_reg;
   logic [ENTRIES-1:0][CTR_BITS-1:0]   ctr_value;

   logic [IDX_BITS-1:0] f_idx;
   logic [TAG_BITS-1:0] f_tag;
   logic                f_hit;
   logic                f_taken;
   logic [IDX_BITS-1:0] x_idx;
   logic [TAG_BITS-1:0] x_tag;
   logic                x_hit;
   logic                x_alloc;
   logic                x_write_target;
   logic                x_misp;

   logic [2*PC_ALIGN-1:0] unused_pc_bits;
   assign unused_pc_bits = {bus.f_pc[PC_ALIGN-1:0], bus.x_pc[PC_ALIGN-1:0]};

   // Lookup reads current state, so a same-cycle update is not visible yet.
   assign f_idx   = bus.f_pc[IDX_BITS+PC_ALIGN-1:PC_ALIGN];
   assign f_tag   = bus.f_pc[XLEN-1:IDX_BITS+PC_ALIGN];
   assign f_hit   = valid_reg[f_idx] && (tag_mem[f_idx] == f_tag);
   assign f_taken = f_hit && ctr_value[f_idx][CTR_BITS-1];

   assign bus.f_predict_taken  = f_taken;
   assign bus.f_predict_target = f_taken ? target_mem[f_idx] : '0;

   assign x_misp = bus.x_update_valid &&
                   ((bus.x_pred_taken != bus.x_taken) ||
                    (bus.x_taken && (bus.x_pred_target != bus.x_target)));
   assign bus.x_mispredict = x_misp;

   assign x_idx   = bus.x_pc[IDX_BITS+PC_ALIGN-1:PC_ALIGN];
   assign x_tag   = bus.x_pc[XLEN-1:IDX_BITS+PC_ALIGN];
   assign x_hit   = valid_reg[x_idx] && (tag_mem[x_idx] == x_tag);
   assign x_alloc = bus.x_update_valid && !x_hit && (bus.x_taken || bus.x_is_jump);
   // Both a taken/jump hit and an allocation rewrite tag and target.
   assign x_write_target = bus.x_update_valid && (bus.x_taken || bus.x_is_jump);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_reg <= '0;
      end else if (x_alloc) begin
         valid_reg[x_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && x_write_target) begin
         tag_mem[x_idx]    <= x_tag;
         target_mem[x_idx] <= bus.x_target;
      end
   end

   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic sel;
         logic hit_upd;
         assign sel     = bus.x_update_valid && (x_idx == IDX_BITS'(gi));
         assign hit_upd = sel && x_hit;

         sat_counter #(
            .WIDTH   (CTR_BITS),
            .RST_VAL (CTR_RST)
         ) u_dir_ctr (
            .clock      (clock),
            .reset      (reset),
            .inc        (hit_upd && !bus.x_is_jump && bus.x_taken),
            .dec        (hit_upd && !bus.x_is_jump && !bus.x_taken),
            .set_max    (hit_upd && bus.x_is_jump),
            .load       (sel && x_alloc),
            .load_value (bus.x_is_jump ? CTR_MAX : CTR_ALLOC),
            .value      (ctr_value[gi])
         );
      end
   endgenerate

   sat_counter #(
      .WIDTH   (STAT_WIDTH),
      .RST_VAL ('0)
   ) u_stat_hits (
      .clock      (clock),
      .reset      (reset),
      .inc        (bus.f_lookup_valid && f_taken),
      .dec        (1'b0),
      .set_max    (1'b0),
      .load       (1'b0),
      .load_value ('0),
      .value      (stat_hits)
   );

   sat_counter #(
      .WIDTH   (STAT_WIDTH),
      .RST_VAL ('0)
   ) u_stat_misp (
      .clock      (clock),
      .reset      (reset),
      .inc        (x_misp),
      .dec        (1'b0),
      .set_max    (1'b0),
      .load       (1'b0),
      .load_value ('0),
      .value      (stat_mispredicts)
   );
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed plus randomized bench for branch_predictor_btb, checked every cycle
// against a behavioural BTB model.
module tb_branch_predictor_btb;
   localparam int XLEN = 32;
   localparam int ENT  = 16;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [SW-1:0] stat_hits;
   logic [SW-1:0] stat_mispredicts;

   int n_cmp  = 0;
   int n_fail = 0;

   branch_predictor_btb_if #(.XLEN(XLEN)) bus ();

   branch_predictor_btb #(
      .XLEN(XLEN), .ENTRIES(ENT), .CTR_BITS(2), .STAT_WIDTH(SW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .bus              (bus),
      .stat_hits        (stat_hits),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input bit verbose);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h want 0x%08h", name, $time, act, exp);
      end else if (verbose) begin
         $display("check %s: 0x%08h ok", name, act);
      end
   endtask

   task automatic drive(input logic rst, input logic lv, input logic [31:0] fpc,
                        input logic uv, input logic [31:0] xpc, input logic jmp,
                        input logic tkn, input logic [31:0] tgt,
                        input logic ptkn, input logic [31:0] ptgt);
      @(posedge clock);
      #1;
      reset              = rst;
      bus.f_lookup_valid = lv;
      bus.f_pc           = fpc;
      bus.x_update_valid = uv;
      bus.x_pc           = xpc;
      bus.x_is_jump      = jmp;
      bus.x_taken        = tkn;
      bus.x_target       = tgt;
      bus.x_pred_taken   = ptkn;
      bus.x_pred_target  = ptgt;
   endtask

   task automatic lookup(input logic [31:0] fpc);
      drive(1'b0, 1'b1, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #3;
   endtask

   // Behavioural model: a table indexed by word address, direction as 0..3.
   bit          m_valid [ENT];
   logic [31:0] m_tag   [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_ctr   [ENT];
   int          m_hits = 0;
   int          m_misp = 0;

   initial begin
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
   end

   initial begin : compare
      int          fi, xi;
      bit          fhit, ept, emisp, xhit;
      logic [31:0] etgt;
      @(posedge clock);
      forever begin
         @(negedge clock);
         fi    = int'((bus.f_pc >> 2) % ENT);
         fhit  = m_valid[fi] && (m_tag[fi] == (bus.f_pc >> 6));
         ept   = fhit && (m_ctr[fi] >= 2);
         etgt  = ept ? m_tgt[fi] : 32'h0;
         emisp = bus.x_update_valid &&
                 ((bus.x_pred_taken != bus.x_taken) ||
                  (bus.x_taken && (bus.x_pred_target != bus.x_target)));
         check("predict_taken",  32'(bus.f_predict_taken), 32'(ept),   1'b0);
         check("predict_target", bus.f_predict_target,     etgt,       1'b0);
         check("mispredict",     32'(bus.x_mispredict),    32'(emisp), 1'b0);
         check("stat_hits",      32'(stat_hits),           m_hits,     1'b0);
         check("stat_misp",      32'(stat_mispredicts),    m_misp,     1'b0);
         if (reset) begin
            for (int i = 0; i < ENT; i++) begin
               m_valid[i] = 1'b0;
               m_ctr[i]   = 1;
            end
            m_hits = 0;
            m_misp = 0;
         end else begin
            if (bus.f_lookup_valid && ept && m_hits < SMAX) m_hits++;
            if (emisp && m_misp < SMAX) m_misp++;
            if (bus.x_update_valid) begin
               xi   = int'((bus.x_pc >> 2) % ENT);
               xhit = m_valid[xi] && (m_tag[xi] == (bus.x_pc >> 6));
               if (xhit) begin
                  if (bus.x_is_jump) begin
                     m_ctr[xi] = 3;
                     m_tgt[xi] = bus.x_target;
                  end else if (bus.x_taken) begin
                     m_ctr[xi] = (m_ctr[xi] < 3) ? m_ctr[xi] + 1 : 3;
                     m_tgt[xi] = bus.x_target;
                  end else begin
                     m_ctr[xi] = (m_ctr[xi] > 0) ? m_ctr[xi] - 1 : 0;
                  end
               end else if (bus.x_taken || bus.x_is_jump) begin
                  m_valid[xi] = 1'b1;
                  m_tag[xi]   = bus.x_pc >> 6;
                  m_tgt[xi]   = bus.x_target;
                  m_ctr[xi]   = bus.x_is_jump ? 3 : 2;
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [31:0] pc, tgt, ptgt;
      logic        lv, uv, jmp, tkn, ptkn, rst;
      reset              = 1'b1;
      bus.f_lookup_valid = 1'b0;
      bus.f_pc           = '0;
      bus.x_update_valid = 1'b0;
      bus.x_pc           = '0;
      bus.x_is_jump      = 1'b0;
      bus.x_taken        = 1'b0;
      bus.x_target       = '0;
      bus.x_pred_taken   = 1'b0;
      bus.x_pred_target  = '0;

      // Reset state
      lookup(32'h0100_0000);
      check("reset_taken",  32'(bus.f_predict_taken), 32'h0, 1'b1);
      check("reset_target", bus.f_predict_target,     32'h0, 1'b1);
      check("reset_hits",   32'(stat_hits),           32'h0, 1'b1);
      check("reset_misp",   32'(stat_mispredicts),    32'h0, 1'b1);

      // First taken resolve allocates weakly-taken and flags a mispredict
      drive(0, 0, 0, 1, 32'h0100_0010, 0, 1, 32'h0100_0040, 0, 32'h0);
      #3 check("alloc_misp", 32'(bus.x_mispredict), 32'h1, 1'b1);
      lookup(32'h0100_0010);
      check("alloc_taken",  32'(bus.f_predict_taken), 32'h1,         1'b1);
      check("alloc_target", bus.f_predict_target,     32'h0100_0040, 1'b1);
      check("alloc_stat",   32'(stat_mispredicts),    32'h1,         1'b1);

      // 10 -> 01 -> 00, then saturate, then one taken: still not-taken
      repeat (2) drive(0, 0, 0, 1, 32'h0100_0010, 0, 0, 32'h0, 1, 32'h0100_0040);
      lookup(32'h0100_0010);
      check("nt_taken", 32'(bus.f_predict_taken), 32'h0, 1'b1);
      drive(0, 0, 0, 1, 32'h0100_0010, 0, 0, 32'h0, 0, 32'h0);
      drive(0, 0, 0, 1, 32'h0100_0010, 0, 1, 32'h0100_0040, 0, 32'h0);
      lookup(32'h0100_0010);
      check("sat_low_taken", 32'(bus.f_predict_taken), 32'h0, 1'b1);

      // Alias on index 4 replaces the entry
      drive(0, 0, 0, 1, 32'h0100_0050, 0, 1, 32'h0100_0200, 1, 32'h0100_0200);
      lookup(32'h0100_0050);
      check("alias_taken",  32'(bus.f_predict_taken), 32'h1,         1'b1);
      check("alias_target", bus.f_predict_target,     32'h0100_0200, 1'b1);
      lookup(32'h0100_0010);
      check("alias_old_miss", 32'(bus.f_predict_taken), 32'h0, 1'b1);

      // JALR: read-before-write in the update cycle, taken afterwards
      drive(0, 1, 32'h0100_0020, 1, 32'h0100_0020, 1, 1, 32'h0100_0100, 0, 32'h0);
      #3 check("jump_same_cycle", 32'(bus.f_predict_taken), 32'h0, 1'b1);
      lookup(32'h0100_0020);
      check("jump_taken",  32'(bus.f_predict_taken), 32'h1,         1'b1);
      check("jump_target", bus.f_predict_target,     32'h0100_0100, 1'b1);

      // Mispredict counter saturates at 15
      repeat (20) drive(0, 0, 0, 1, 32'h0100_0030, 0, 0, 32'h0, 1, 32'h0);
      lookup(32'h0100_0000);
      check("misp_saturate", 32'(stat_mispredicts), 32'd15, 1'b1);

      // Reset with a concurrent jump update: update discarded
      drive(1, 1, 32'h0100_0020, 1, 32'h0100_0070, 1, 1, 32'h0100_0300, 0, 32'h0);
      lookup(32'h0100_0070);
      check("rst_upd_dropped", 32'(bus.f_predict_taken), 32'h0, 1'b1);
      check("rst_misp",        32'(stat_mispredicts),    32'h0, 1'b1);
      check("rst_hits",        32'(stat_hits),           32'h0, 1'b1);
      lookup(32'h0100_0020);
      check("rst_entry_gone", 32'(bus.f_predict_taken), 32'h0, 1'b1);

      // Random traffic over a small PC pool so entries hit and alias
      for (int i = 0; i < 1500; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         lv   = ($urandom_range(0, 3) != 0);
         uv   = ($urandom_range(0, 2) != 0);
         jmp  = ($urandom_range(0, 5) == 0);
         tkn  = jmp | $urandom_range(0, 1);
         ptkn = $urandom_range(0, 1);
         tgt  = 32'h0200_0000 | ($urandom_range(0, 7) << 2);
         ptgt = 32'h0200_0000 | ($urandom_range(0, 7) << 2);
         pc   = 32'h0100_0000 | ($urandom_range(0, 1) << 6) |
                ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         drive(rst, lv, 32'h0100_0000 | ($urandom_range(0, 1) << 6) |
               ($urandom_range(0, 15) << 2), uv, pc, jmp, tkn, tgt, ptkn, ptgt);
         if (uv)
            $display("txn %0d: rst=%0d pc=0x%08h jump=%0d taken=%0d target=0x%08h",
                     i, rst, pc, jmp, tkn, tgt);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #6;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. Replaces fixed "predict not-taken, flush on resolve" behaviour at fetch. Lookup is combinational on the fetch PC and feeds the PC select mux; update comes from the execute stage when a branch or jump resolves. The block also flags mispredicts and keeps saturating hit and mispredict statistics counters for the bench and perf reporting.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB depth; power of two, minimum 2
CTR_BITS, 2, direction counter width; minimum 1
STAT_WIDTH, 32, width of the hit and mispredict counters
IDX_BITS, log2(ENTRIES), derived; not overridable
TAG_BITS, XLEN-IDX_BITS-2, derived; not overridable

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
f_pc  in  XLEN  fetch-stage PC to look up
f_lookup_valid  in  1  fetch is presenting a real lookup (not stalled)
f_predict_taken  out  1  hit and counter MSB set
f_predict_target  out  XLEN  stored target; 0 when f_predict_taken=0
x_update_valid  in  1  a branch or jump resolves in X this cycle
x_pc  in  XLEN  PC of the resolving instruction
x_is_jump  in  1  JAL/JALR (unconditional)
x_taken  in  1  actual direction
x_target  in  XLEN  actual target (ALU out)
x_pred_taken  in  1  prediction carried down the pipe with the instruction
x_pred_target  in  XLEN  predicted target carried down the pipe
x_mispredict  out  1  combinational redirect request
stat_hits  out  STAT_WIDTH  lookups that predicted taken
stat_mispredicts  out  STAT_WIDTH  mispredict count

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[XLEN-1:IDX_BITS+2]. pc[1:0] is ignored.
- Entry contents: valid bit, tag, target, counter.
- Reset state:
  - All valid bits cleared. All counters set to weakly-not-taken (MSB 0, other bits 1; CTR_BITS=1 gives 0).
  - Stats cleared. All outputs read 0.
  - Target and tag storage need no reset.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - f_predict_taken = hit & ctr[MSB].
  - Reads return the pre-update value if an update to the same index occurs in the same cycle (read-before-write).
- Mispredict (combinational):
  - x_mispredict = x_update_valid & ((x_pred_taken != x_taken) | (x_taken & x_pred_target != x_target)).
- Update, on the clock edge when x_update_valid:
  - Hit, conditional branch: counter increments on taken, decrements on not-taken, saturating at 0 and all-ones. Target is overwritten only when taken.
  - Hit, jump: counter set to all-ones; target overwritten.
  - Miss and (taken or jump): allocate the entry (overwrites any alias). Set valid, tag and target. Counter = all-ones for a jump, otherwise weakly-taken (MSB 1, other bits 0).
  - Miss and not-taken: no allocation, no state change.
- Stats, each saturating at all-ones (no wrap):
  - stat_hits increments when f_lookup_valid & f_predict_taken.
  - stat_mispredicts increments when x_mispredict.
- Reset asserted mid-operation: all state returns to the reset state on that edge. Any update presented in the same cycle is discarded.
- The caller gates x_update_valid for flushed or bubble instructions. The block performs no flush logic itself.

Decomposition:
- Shared package, pipeline-wide: XLEN default, PC alignment constant (2), and counter encodings (SNT, WNT, WT, ST for the 2-bit case).
- Sub-module sat_counter (parametrised width, inc/dec/set-max, saturating). Reused for the direction counters and, with set-max tied off, for both stat counters.
- Entry storage stays as flat arrays inside the top.

Test Plan:
- Reset, then lookup f_pc=0x01000000 -> f_predict_taken=0, f_predict_target=0, stats 0.
- Update x_pc=0x01000010, taken, x_target=0x01000040, x_pred_taken=0 -> x_mispredict=1 that cycle. Next lookup of 0x01000010 -> taken, target 0x01000040. stat_mispredicts=1.
- Two not-taken updates to 0x01000010 -> counter goes 10->01->00. Lookup predicts not-taken while the entry stays valid. A third not-taken update leaves the counter at 00.
- ENTRIES=16: allocate taken at 0x01000010, then a taken update at 0x01000050 (same index 4) -> 0x01000050 hits with its own target; 0x01000010 misses.
- JALR update x_pc=0x01000020, x_is_jump=1, x_target=0x01000100 -> counter=11. A lookup to the same index in the same cycle shows the old value; the next cycle predicts taken to 0x01000100.
- STAT_WIDTH=4: 20 mispredicts -> stat_mispredicts holds at 15. Assert reset mid-run with a concurrent update -> all entries invalid, stats 0, the update is not applied.
